// File: rtl/match_string_loader_if.sv
// Host-side load port and active-string outputs of the match string loader.
// The master modport drives the host inputs; the slave modport is the loader.
interface match_string_loader_if #(
  parameter int MAX_LEN = 17,
  parameter int PTR_W   = 5
);
  logic                       wr_start;
  logic                       wr_en;
  logic [7:0]                 wr_data;
  logic                       wr_commit;
  logic                       pkt_boundary;
  logic [0:MAX_LEN-1][7:0]    string_out;
  logic [PTR_W-1:0]           strlen_out;
  logic                       str_valid;
  logic                       comp_clear;
  logic                       busy;
  logic                       error;

  modport master (
    output wr_start, wr_en, wr_data, wr_commit, pkt_boundary,
    input  string_out, strlen_out, str_valid, comp_clear, busy, error
  );

  modport slave (
    input  wr_start, wr_en, wr_data, wr_commit, pkt_boundary,
    output string_out, strlen_out, str_valid, comp_clear, busy, error
  );
endinterface

// File: rtl/match_string_loader.sv
// Loads a match string byte-by-byte into a shadow buffer and commits it to the
// active outputs only at a packet boundary, pulsing comp_clear on each commit.
module match_string_loader #(
  parameter int MAX_LEN = 17,
  parameter int PTR_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  match_string_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

  state_t                  state_q, state_d;
  logic [0:MAX_LEN-1][7:0] shadow_q, shadow_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [0:MAX_LEN-1][7:0] string_q, string_d;
  logic [PTR_W-1:0]        strlen_q, strlen_d;
  logic                    str_valid_q, str_valid_d;
  logic                    comp_clear_q, comp_clear_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic [PTR_W-1:0]        cnt;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    wr_ptr_d     = wr_ptr_q;
    string_d     = string_q;
    strlen_d     = strlen_q;
    str_valid_d  = str_valid_q;
    comp_clear_d = 1'b0;
    error_d      = error_q;
    cnt          = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (bus.wr_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          shadow_d = '0;
          error_d  = 1'b0;
        end
      end
      LOAD: begin
        if (bus.wr_start) begin
          wr_ptr_d = '0;
          shadow_d = '0;
          error_d  = 1'b0;
        end else begin
          // The byte lands before the commit so the commit count includes it.
          if (bus.wr_en) begin
            if (wr_ptr_q < PTR_W'(MAX_LEN)) begin
              shadow_d[wr_ptr_q] = bus.wr_data;
              cnt                = wr_ptr_q + PTR_W'(1);
              wr_ptr_d           = cnt;
            end else begin
              error_d = 1'b1;
            end
          end
          if (bus.wr_commit) begin
            if (cnt == '0) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PENDING;
            end
          end
        end
      end
      PENDING: begin
        if (bus.wr_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          shadow_d = '0;
          error_d  = 1'b0;
        end else if (bus.pkt_boundary) begin
          string_d     = shadow_q;
          strlen_d     = wr_ptr_q - PTR_W'(1);
          str_valid_d  = 1'b1;
          comp_clear_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      wr_ptr_q     <= '0;
      string_q     <= '0;
      strlen_q     <= '0;
      str_valid_q  <= 1'b0;
      comp_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      wr_ptr_q     <= wr_ptr_d;
      string_q     <= string_d;
      strlen_q     <= strlen_d;
      str_valid_q  <= str_valid_d;
      comp_clear_q <= comp_clear_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign bus.string_out = string_q;
  assign bus.strlen_out = strlen_q;
  assign bus.str_valid  = str_valid_q;
  assign bus.comp_clear = comp_clear_q;
  assign bus.busy       = busy_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_match_string_loader.sv
// Directed bench for match_string_loader: loads, deferred commits, overflow,
// empty commit, restart while pending and reset while pending.
module tb_match_string_loader;
  localparam int MAX_LEN = 17;
  localparam int PTR_W   = 5;
  localparam int SW      = MAX_LEN * 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [0:MAX_LEN-1][7:0] exp_str;
  logic [0:MAX_LEN-1][7:0] prev_str;

  match_string_loader_if #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) bus ();

  match_string_loader #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [SW-1:0] observed,
                       input logic [SW-1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst              = 1'b1;
    bus.wr_start     = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.wr_commit    = 1'b0;
    bus.pkt_boundary = 1'b0;
    step();
    step();

    // Reset state
    check("rst_string", SW'(bus.string_out), '0);
    check("rst_strlen", SW'(bus.strlen_out), '0);
    check("rst_valid",  SW'(bus.str_valid),  '0);
    check("rst_clear",  SW'(bus.comp_clear), '0);
    check("rst_busy",   SW'(bus.busy),       '0);
    check("rst_error",  SW'(bus.error),      '0);
    rst = 1'b0;
    step();

    // Test 1: "evil" committed with pkt_boundary high
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("t1_busy_load", SW'(bus.busy), SW'(1'b1));
    write_byte(8'h65);
    write_byte(8'h76);
    write_byte(8'h69);
    write_byte(8'h6C);
    bus.pkt_boundary = 1'b1;
    bus.wr_commit    = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("t1_pending_clear", SW'(bus.comp_clear), '0);
    check("t1_pending_busy",  SW'(bus.busy),       SW'(1'b1));
    check("t1_pending_valid", SW'(bus.str_valid),  '0);
    step();
    exp_str = '0;
    exp_str[0] = 8'h65; exp_str[1] = 8'h76; exp_str[2] = 8'h69; exp_str[3] = 8'h6C;
    check("t1_string", SW'(bus.string_out), SW'(exp_str));
    check("t1_strlen", SW'(bus.strlen_out), SW'(5'd3));
    check("t1_valid",  SW'(bus.str_valid),  SW'(1'b1));
    check("t1_clear",  SW'(bus.comp_clear), SW'(1'b1));
    check("t1_busy",   SW'(bus.busy),       '0);
    step();
    check("t1_clear_off", SW'(bus.comp_clear), '0);
    prev_str = exp_str;

    // Test 2: commit deferred for 10 cycles without a packet boundary
    bus.pkt_boundary = 1'b0;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    write_byte(8'h41);
    bus.wr_en     = 1'b1;
    bus.wr_data   = 8'h42;
    bus.wr_commit = 1'b1;
    step();
    bus.wr_en     = 1'b0;
    bus.wr_commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t2_wait_busy",   SW'(bus.busy),       SW'(1'b1));
      check("t2_wait_string", SW'(bus.string_out), SW'(prev_str));
      check("t2_wait_clear",  SW'(bus.comp_clear), '0);
      step();
    end
    bus.pkt_boundary = 1'b1;
    step();
    exp_str = '0;
    exp_str[0] = 8'h41; exp_str[1] = 8'h42;
    check("t2_string", SW'(bus.string_out), SW'(exp_str));
    check("t2_strlen", SW'(bus.strlen_out), SW'(5'd1));
    check("t2_clear",  SW'(bus.comp_clear), SW'(1'b1));
    check("t2_busy",   SW'(bus.busy),       '0);
    step();
    check("t2_clear_off", SW'(bus.comp_clear), '0);

    // Test 3: overflow, 18 bytes into a 17-byte buffer
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      write_byte(8'(i));
      if (i == 17) check("t3_no_err_yet", SW'(bus.error), '0);
    end
    check("t3_error", SW'(bus.error), SW'(1'b1));
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    step();
    for (int i = 0; i < MAX_LEN; i++) exp_str[i] = 8'(i + 1);
    check("t3_string",     SW'(bus.string_out), SW'(exp_str));
    check("t3_last_byte",  SW'(bus.string_out[16]), SW'(8'h11));
    check("t3_strlen",     SW'(bus.strlen_out), SW'(5'd16));
    check("t3_error_hold", SW'(bus.error),      SW'(1'b1));
    check("t3_clear",      SW'(bus.comp_clear), SW'(1'b1));
    prev_str = exp_str;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("t3_error_cleared", SW'(bus.error), '0);

    // Test 4: commit of an empty string
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("t4_error",  SW'(bus.error),      SW'(1'b1));
    check("t4_busy",   SW'(bus.busy),       '0);
    check("t4_string", SW'(bus.string_out), SW'(prev_str));
    check("t4_strlen", SW'(bus.strlen_out), SW'(5'd16));
    check("t4_clear",  SW'(bus.comp_clear), '0);
    step();
    check("t4_clear_after", SW'(bus.comp_clear), '0);
    check("t4_busy_idle",   SW'(bus.busy),       '0);

    // Test 5: restart while pending discards "ab"
    bus.pkt_boundary = 1'b0;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("t5_error_cleared", SW'(bus.error), '0);
    write_byte(8'h61);
    write_byte(8'h62);
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    bus.wr_start  = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("t5_restart_busy",   SW'(bus.busy),       SW'(1'b1));
    check("t5_restart_string", SW'(bus.string_out), SW'(prev_str));
    bus.pkt_boundary = 1'b1;
    check("t5_no_commit_clear", SW'(bus.comp_clear), '0);
    write_byte(8'h78);
    write_byte(8'h79);
    write_byte(8'h7A);
    check("t5_load_string", SW'(bus.string_out), SW'(prev_str));
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("t5_pending_string", SW'(bus.string_out), SW'(prev_str));
    step();
    exp_str = '0;
    exp_str[0] = 8'h78; exp_str[1] = 8'h79; exp_str[2] = 8'h7A;
    check("t5_string", SW'(bus.string_out), SW'(exp_str));
    check("t5_strlen", SW'(bus.strlen_out), SW'(5'd2));
    check("t5_clear",  SW'(bus.comp_clear), SW'(1'b1));

    // Test 6: reset while pending with pkt_boundary high
    bus.pkt_boundary = 1'b0;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    write_byte(8'h55);
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    check("t6_pending_busy", SW'(bus.busy), SW'(1'b1));
    bus.pkt_boundary = 1'b1;
    rst = 1'b1;
    step();
    check("t6_string", SW'(bus.string_out), '0);
    check("t6_strlen", SW'(bus.strlen_out), '0);
    check("t6_valid",  SW'(bus.str_valid),  '0);
    check("t6_clear",  SW'(bus.comp_clear), '0);
    check("t6_busy",   SW'(bus.busy),       '0);
    check("t6_error",  SW'(bus.error),      '0);
    rst = 1'b0;
    step();
    check("t6_clear_after", SW'(bus.comp_clear), '0);
    check("t6_valid_after", SW'(bus.str_valid),  '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/match_string_loader.md
Name: match_string_loader

Overview:
- Upstream stage of the string comparator. Accepts a match string from the Atom host, one byte per write.
- Holds the bytes in a shadow buffer. Commits the string to the active outputs only at a packet boundary, so the string under test never changes mid-packet.
- On commit, pulses a clear to the comparator so that it flushes stale stream bytes.

Parameters:
MAX_LEN, 17, maximum string length in bytes; sets the string_out depth.
PTR_W, 5, pointer/length width; must satisfy 2^PTR_W > MAX_LEN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
wr_start  in  1  begin a new string load; discards the shadow contents
wr_en  in  1  write wr_data into the shadow buffer at the current pointer
wr_data  in  8  string byte from the host
wr_commit  in  1  request that the shadow string become active
pkt_boundary  in  1  high while the monitored stream is between packets
string_out  out  [0:MAX_LEN-1][7:0]  active string; index 0 is the first byte written
strlen_out  out  PTR_W  active length minus 1, i.e. the index of the last valid byte
str_valid  out  1  an active string has been committed since reset
comp_clear  out  1  one-cycle clear pulse to the comparator
busy  out  1  load or commit in progress
error  out  1  sticky: overflow, or commit of an empty string

Behaviour:
- Reset: on any rising clk edge with rst=1, all state is cleared regardless of state or inputs.
  - string_out=0, strlen_out=0, str_valid=0, comp_clear=0, busy=0, error=0.
  - Shadow buffer and wr_ptr are zeroed; FSM goes to IDLE.
- All outputs are registered.
- FSM states: IDLE, LOAD, PENDING.
- IDLE:
  - wr_en and wr_commit are ignored.
  - wr_start -> LOAD. Same edge: wr_ptr=0, shadow zeroed, error cleared.
- LOAD:
  - wr_en with wr_ptr<MAX_LEN: shadow[wr_ptr]<=wr_data, wr_ptr increments.
  - wr_en with wr_ptr==MAX_LEN: byte dropped, error<=1, state unchanged.
  - wr_commit with effective count 0: error<=1, -> IDLE, active outputs unchanged.
  - wr_commit with effective count >0: -> PENDING.
  - wr_en and wr_commit in the same cycle: the byte is written first, and the count used by the commit includes it.
  - wr_start in LOAD, including together with wr_en/wr_commit: restart. wr_ptr=0, shadow zeroed, error cleared; wr_en/wr_commit are ignored that cycle.
- PENDING:
  - wr_en and wr_commit are ignored.
  - wr_start: abandon the pending commit, -> LOAD with restart semantics.
  - pkt_boundary=1 and no wr_start: on that edge the commit happens, then -> IDLE.
    - string_out<=shadow, with unwritten bytes zero.
    - strlen_out<=wr_ptr-1.
    - str_valid<=1.
    - comp_clear<=1 for exactly one cycle.
  - pkt_boundary already high on PENDING entry: commit on the next edge. Commit latency is 1 cycle after the wr_commit edge.
- busy=1 in LOAD and PENDING, 0 in IDLE. Registered with the state.
- comp_clear is 0 in every cycle except the cycle after a commit edge.
- strlen_out arithmetic is PTR_W bits wide. Maximum value is MAX_LEN-1 (16). No wrap is possible, because a commit with count 0 is rejected.
- Active outputs hold their value until the next successful commit or rst; the host load sequence does not disturb them.
- error stays set until the next wr_start or rst.

Test Plan:
1. Reset, then wr_start; write 0x65,0x76,0x69,0x6C; wr_commit with pkt_boundary=1 -> one cycle later: string_out[0:3]=65 76 69 6C, bytes 4..16=0, strlen_out=3, str_valid=1, comp_clear high exactly one cycle, busy=0.
2. Commit with pkt_boundary=0 for 10 cycles, then pkt_boundary=1 -> outputs unchanged and busy=1 for those 10 cycles; commit on the first edge with pkt_boundary=1; comp_clear pulses once.
3. wr_start; write 18 bytes 0x01..0x12; commit -> error=1; string_out[16]=0x11, 0x12 dropped; strlen_out=16; next wr_start clears error.
4. wr_start, then immediately wr_commit -> error=1, state IDLE, previous active string and strlen_out unchanged, comp_clear stays 0.
5. Load "ab" and commit while pkt_boundary=0; assert wr_start while PENDING; load "xyz" and commit with pkt_boundary=1 -> string_out[0:2]="xyz", strlen_out=2, "ab" never appears on the outputs.
6. Assert rst while PENDING with pkt_boundary=1 -> next cycle all outputs 0, busy=0, no comp_clear pulse.
